// File: rtl/qkv_proj_stream.sv
`default_nettype none
// ============================================================================
// Module      : qkv_proj_stream
// Description : Streaming Q/K/V projection. Each accepted token vector is
//               multiplied by three run-time-loadable weight matrices using a
//               shared sequential MAC schedule (one product per matrix per
//               cycle), then rounded half-up and saturated per output element.
// Revision    : 1.0 - initial release
// ============================================================================
module qkv_proj_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int EMBED_DIM  = 8,
    parameter int HEAD_DIM   = 8,
    parameter int FRAC_BITS  = 14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*EMBED_DIM-1:0]  in_vec_flat,
    input  logic                             wr_en,
    input  logic [1:0]                       wr_sel,
    input  logic [$clog2(HEAD_DIM)-1:0]      wr_row,
    input  logic [$clog2(EMBED_DIM)-1:0]     wr_col,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             wr_err,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*HEAD_DIM-1:0]   Q_flat,
    output logic [DATA_WIDTH*HEAD_DIM-1:0]   K_flat,
    output logic [DATA_WIDTH*HEAD_DIM-1:0]   V_flat,
    output logic                             sat_flag
);

    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(EMBED_DIM) + 1;
    localparam int c_ROW_W   = $clog2(HEAD_DIM);
    localparam int c_COL_W   = $clog2(EMBED_DIM);
    localparam int c_PROD_W  = 2*DATA_WIDTH;
    localparam int c_NMAT    = 3;

    localparam logic signed [DATA_WIDTH-1:0] c_ONE  = DATA_WIDTH'(2**FRAC_BITS);
    localparam logic signed [ACC_WIDTH-1:0]  c_HALF = ACC_WIDTH'(2**(FRAC_BITS-1));
    localparam logic signed [ACC_WIDTH-1:0]  c_MAX  = ACC_WIDTH'(2**(DATA_WIDTH-1)-1);
    // Bitwise inverse of the positive limit is exactly the negative limit.
    localparam logic signed [ACC_WIDTH-1:0]  c_MIN  = ~c_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [c_ROW_W-1:0]             r_h;
    logic [c_COL_W-1:0]             r_e;
    logic signed [DATA_WIDTH-1:0]   r_tok [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0]   r_w   [c_NMAT][HEAD_DIM][EMBED_DIM];
    logic signed [ACC_WIDTH-1:0]    r_acc [c_NMAT];
    logic signed [DATA_WIDTH-1:0]   r_res [c_NMAT][HEAD_DIM];
    logic                           r_sat;
    logic                           r_wr_err;

    logic signed [c_PROD_W-1:0]     w_prod [c_NMAT];
    logic signed [ACC_WIDTH-1:0]    w_sum  [c_NMAT];
    logic signed [ACC_WIDTH-1:0]    w_rnd  [c_NMAT];
    logic signed [DATA_WIDTH-1:0]   w_clip [c_NMAT];
    logic                           w_any_sat;
    logic                           w_last_e;
    logic                           w_last_h;
    logic                           w_wr_ok;
    logic                           w_wr_bad;

    assign w_last_e = (r_e == c_COL_W'(EMBED_DIM-1));
    assign w_last_h = (r_h == c_ROW_W'(HEAD_DIM-1));

    // A write lands only in IDLE, to a real matrix, at an in-range address.
    assign w_wr_ok  = wr_en && (r_state == S_IDLE) && (wr_sel != 2'd3)
                      && (int'(wr_row) < HEAD_DIM) && (int'(wr_col) < EMBED_DIM);
    assign w_wr_bad = wr_en && !w_wr_ok;

    // MAC products plus round-half-up and saturation of the running sums.
    always_comb begin
        w_any_sat = 1'b0;
        for (int m = 0; m < c_NMAT; m++) begin
            w_prod[m] = c_PROD_W'(r_tok[r_e]) * c_PROD_W'(r_w[m][r_h][r_e]);
            w_sum[m]  = r_acc[m] + c_HALF;
            w_rnd[m]  = w_sum[m] >>> FRAC_BITS;
            if (w_rnd[m] > c_MAX) begin
                w_clip[m] = DATA_WIDTH'(c_MAX);
                w_any_sat = 1'b1;
            end else if (w_rnd[m] < c_MIN) begin
                w_clip[m] = DATA_WIDTH'(c_MIN);
                w_any_sat = 1'b1;
            end else begin
                w_clip[m] = DATA_WIDTH'(w_rnd[m]);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last_e) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_last_h ? S_OUT : S_CALC;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    // Weight register file; identity after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < c_NMAT; m++) begin
                for (int h = 0; h < HEAD_DIM; h++) begin
                    for (int e = 0; e < EMBED_DIM; e++) begin
                        r_w[m][h][e] <= (h == e) ? c_ONE : '0;
                    end
                end
            end
        end else if (w_wr_ok) begin
            r_w[wr_sel][wr_row][wr_col] <= wr_data;
        end
    end

    // Token capture, counters, accumulators, result registers and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h      <= '0;
            r_e      <= '0;
            r_sat    <= 1'b0;
            r_wr_err <= 1'b0;
            for (int e = 0; e < EMBED_DIM; e++) begin
                r_tok[e] <= '0;
            end
            for (int m = 0; m < c_NMAT; m++) begin
                r_acc[m] <= '0;
                for (int h = 0; h < HEAD_DIM; h++) begin
                    r_res[m][h] <= '0;
                end
            end
        end else begin
            r_wr_err <= w_wr_bad;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_h <= '0;
                        r_e <= '0;
                        for (int e = 0; e < EMBED_DIM; e++) begin
                            r_tok[e] <= in_vec_flat[e*DATA_WIDTH +: DATA_WIDTH];
                        end
                        for (int m = 0; m < c_NMAT; m++) begin
                            r_acc[m] <= '0;
                        end
                    end
                end
                S_CALC: begin
                    for (int m = 0; m < c_NMAT; m++) begin
                        r_acc[m] <= r_acc[m] + ACC_WIDTH'(w_prod[m]);
                    end
                    r_e <= w_last_e ? '0 : r_e + 1'b1;
                end
                S_WRITE: begin
                    for (int m = 0; m < c_NMAT; m++) begin
                        r_res[m][r_h] <= w_clip[m];
                    end
                    if (w_any_sat) begin
                        r_sat <= 1'b1;
                    end
                    if (!w_last_h) begin
                        r_h <= r_h + 1'b1;
                        r_e <= '0;
                        for (int m = 0; m < c_NMAT; m++) begin
                            r_acc[m] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_err   = r_wr_err;
    assign sat_flag = r_sat;

    generate
        for (genvar gh = 0; gh < HEAD_DIM; gh++) begin : g_out
            assign Q_flat[gh*DATA_WIDTH +: DATA_WIDTH] = r_res[0][gh];
            assign K_flat[gh*DATA_WIDTH +: DATA_WIDTH] = r_res[1][gh];
            assign V_flat[gh*DATA_WIDTH +: DATA_WIDTH] = r_res[2][gh];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_qkv_proj_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_qkv_proj_stream
// Description : Self-checking bench for qkv_proj_stream. Directed scenarios
//               plus random weights/tokens compared with a behavioural model
//               that evaluates the projection with 64-bit integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qkv_proj_stream;

    localparam int DW  = 16;
    localparam int ED  = 8;
    localparam int HD  = 8;
    localparam int LAT = HD * (ED + 1);

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DW*ED-1:0]   in_vec_flat;
    logic               wr_en;
    logic [1:0]         wr_sel;
    logic [2:0]         wr_row;
    logic [2:0]         wr_col;
    logic [DW-1:0]      wr_data;
    logic               wr_err;
    logic               out_valid;
    logic               out_ready;
    logic [DW*HD-1:0]   Q_flat;
    logic [DW*HD-1:0]   K_flat;
    logic [DW*HD-1:0]   V_flat;
    logic               sat_flag;

    int                 n_checks = 0;
    int                 n_err    = 0;

    // Reference model state
    int                 mw [3][HD][ED];
    int                 tok [ED];
    logic [DW*ED-1:0]   tok_flat;
    logic [DW*HD-1:0]   exp_f [3];
    logic [DW*HD-1:0]   saved [3];
    bit                 sat_m;

    qkv_proj_stream #(
        .DATA_WIDTH (DW),
        .EMBED_DIM  (ED),
        .HEAD_DIM   (HD),
        .FRAC_BITS  (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec_flat (in_vec_flat),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Q_flat      (Q_flat),
        .K_flat      (K_flat),
        .V_flat      (V_flat),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++)
            for (int h = 0; h < HD; h++)
                for (int e = 0; e < ED; e++)
                    mw[m][h][e] = (h == e) ? 16384 : 0;
        sat_m = 1'b0;
    endtask

    // Expected results for the current token and model weights.
    task automatic prepare();
        longint s, n, q;
        for (int e = 0; e < ED; e++) tok_flat[e*DW +: DW] = 16'(tok[e]);
        for (int m = 0; m < 3; m++) begin
            for (int h = 0; h < HD; h++) begin
                s = 0;
                for (int e = 0; e < ED; e++) s += longint'(tok[e]) * longint'(mw[m][h][e]);
                // value/16384 + 0.5, floored
                n = s + 8192;
                q = n / 16384;
                if (n < 0 && (n % 16384) != 0) q = q - 1;
                if (q > 32767) begin q = 32767; sat_m = 1'b1; end
                else if (q < -32768) begin q = -32768; sat_m = 1'b1; end
                exp_f[m][h*DW +: DW] = 16'(q);
            end
        end
    endtask

    task automatic rand_token();
        for (int e = 0; e < ED; e++) tok[e] = int'($signed(16'($urandom)));
    endtask

    task automatic wr(input int sel, input int row, input int col, input int data, input bit bad);
        wr_en = 1'b1; wr_sel = 2'(sel); wr_row = 3'(row); wr_col = 3'(col); wr_data = 16'(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("wr_err_after_write", wr_err, bad);
        if (!bad) mw[sel][row][col] = data;
        @(posedge clk); #1;
        check("wr_err_clears", wr_err, 1'b0);
    endtask

    task automatic accept(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_vec_flat = tok_flat;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec_flat = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Waits for out_valid; optionally attempts a weight write mid-calculation.
    task automatic wait_result(input string tag, input int inj);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (inj >= 0 && cyc == inj) begin
                wr_en = 1'b1; wr_sel = 2'd1; wr_row = 3'd1; wr_col = 3'd1; wr_data = 16'd0;
            end
            @(posedge clk); #1;
            cyc++;
            if (inj >= 0 && cyc == inj + 1) begin
                wr_en = 1'b0;
                check({tag, "_calc_wr_err"}, wr_err, 1'b1);
            end
            if (inj >= 0 && cyc == inj + 2) check({tag, "_calc_wr_err_pulse"}, wr_err, 1'b0);
        end
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_Q"}, Q_flat, exp_f[0]);
        check({tag, "_K"}, K_flat, exp_f[1]);
        check({tag, "_V"}, V_flat, exp_f[2]);
        check({tag, "_sat"}, sat_flag, sat_m);
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 1'b0);
        check({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic run_token(input string tag);
        prepare();
        accept(tag);
        wait_result(tag, -1);
        finish_out(tag);
    endtask

    task automatic set_s1_token();
        tok = '{16384, -8192, 1, 0, 0, 0, 0, 32767};
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec_flat = '0; wr_en = 1'b0; wr_sel = '0;
        wr_row = '0; wr_col = '0; wr_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);
        check("rst_sat", sat_flag, 1'b0);
        check("rst_Q", Q_flat, '0);

        // Identity weights pass the token through
        set_s1_token();
        prepare();
        accept("s1");
        wait_result("s1", -1);
        check("s1_Q_is_x", Q_flat, tok_flat);
        check("s1_V_is_x", V_flat, tok_flat);
        finish_out("s1");

        // Saturation at both rails
        wr(0, 0, 0, 32767, 1'b0);
        tok = '{32767, 0, 0, 0, 0, 0, 0, 0};
        run_token("s2_pos");
        check("s2_Q0_max", Q_flat[15:0], 16'h7fff);
        check("s2_sat_set", sat_flag, 1'b1);
        tok[0] = -32768;
        run_token("s2_neg");
        check("s2_Q0_min", Q_flat[15:0], 16'h8000);

        // Half-up rounding with a 0.5 weight
        wr(2, 0, 0, 8192, 1'b0);
        rand_token(); tok[0] = 3;
        run_token("s3_p3");
        check("s3_V0_p3", V_flat[15:0], 16'd2);
        rand_token(); tok[0] = -3;
        run_token("s3_m3");
        check("s3_V0_m3", V_flat[15:0], 16'hffff);
        rand_token(); tok[0] = 1;
        run_token("s3_p1");
        check("s3_V0_p1", V_flat[15:0], 16'd1);

        // Write attempted mid-calculation is dropped; reserved select dropped
        rand_token();
        prepare();
        accept("s5");
        wait_result("s5", 3);
        finish_out("s5");
        wr(3, 2, 2, 12345, 1'b1);
        rand_token();
        run_token("s5_after_sel3");

        // Random weights and tokens
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++)
                wr($urandom_range(0, 2), $urandom_range(0, HD-1), $urandom_range(0, ED-1),
                   int'($signed(16'($urandom))), 1'b0);
            rand_token();
            run_token("rnd");
        end

        // Back-pressure with a second token pending
        rand_token();
        prepare();
        accept("s4a");
        wait_result("s4a", -1);
        saved = exp_f;
        rand_token();
        prepare();
        in_valid = 1'b1;
        in_vec_flat = tok_flat;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("s4_hold_out_valid", out_valid, 1'b1);
            check("s4_hold_in_ready", in_ready, 1'b0);
            check("s4_hold_Q", Q_flat, saved[0]);
            check("s4_hold_K", K_flat, saved[1]);
            check("s4_hold_V", V_flat, saved[2]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("s4_out_valid_drop", out_valid, 1'b0);
        check("s4_in_ready_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec_flat = {$urandom, $urandom, $urandom, $urandom};
        check("s4_second_accepted", in_ready, 1'b0);
        wait_result("s4b", -1);
        finish_out("s4b");

        // Asynchronous reset in the middle of a calculation
        rand_token();
        prepare();
        accept("s6");
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("s6_rst_out_valid", out_valid, 1'b0);
        check("s6_rst_in_ready", in_ready, 1'b1);
        check("s6_rst_Q", Q_flat, '0);
        check("s6_rst_K", K_flat, '0);
        check("s6_rst_V", V_flat, '0);
        check("s6_rst_sat", sat_flag, 1'b0);
        check("s6_rst_wr_err", wr_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        set_s1_token();
        prepare();
        accept("s6_post");
        wait_result("s6_post", -1);
        check("s6_post_K_is_x", K_flat, tok_flat);
        finish_out("s6_post");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qkv_proj_stream.md
Name: qkv_proj_stream

Overview:
- Next-generation Q/K/V projection for the self-attention datapath. Streams tokens: each token vector x (EMBED_DIM elements) is projected by three run-time-loadable weight matrices into Q, K and V vectors of HEAD_DIM elements.
- One shared sequential MAC schedule; three MACs (Q, K, V) run in lock-step, one element product per matrix per cycle.
- Adds ready/valid handshakes, a weight-load port, round-half-up rescaling and output saturation.

Parameters:
- DATA_WIDTH, 16, signed fixed-point width of inputs, weights and outputs.
- EMBED_DIM, 8, input vector length.
- HEAD_DIM, 8, output vector length per projection.
- FRAC_BITS, 14, fractional bits; 1.0 = 2^FRAC_BITS.
- ACC_WIDTH (localparam), 2*DATA_WIDTH+$clog2(EMBED_DIM)+1, accumulator width; never overflows.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  token vector present.
- in_ready  out  1  block can accept a token.
- in_vec_flat  in  DATA_WIDTH*EMBED_DIM  token; element e at [e*DATA_WIDTH +: DATA_WIDTH].
- wr_en  in  1  weight write strobe.
- wr_sel  in  2  0=W_q, 1=W_k, 2=W_v, 3=reserved (write dropped, wr_err).
- wr_row  in  $clog2(HEAD_DIM)  output index h.
- wr_col  in  $clog2(EMBED_DIM)  input index e.
- wr_data  in  DATA_WIDTH  signed weight.
- wr_err  out  1  one-cycle pulse: write dropped.
- out_valid  out  1  Q/K/V result valid.
- out_ready  in  1  consumer accepts result.
- Q_flat, K_flat, V_flat  out  DATA_WIDTH*HEAD_DIM each  results; element h at [h*DATA_WIDTH +: DATA_WIDTH].
- sat_flag  out  1  sticky: some element saturated since reset.

Behaviour:
- Math: Q[h] = sat(round(sum_e x[e]*W_q[h][e])); K and V are computed the same way with W_k and W_v.
  - Products are full 2*DATA_WIDTH signed and are accumulated in ACC_WIDTH.
  - round(a) = (a + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round-half-up (toward +inf).
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and sets sat_flag.
- Weights are registers. Reset value is identity: W[h][e] = 2^FRAC_BITS if h==e, else 0, for all three matrices.
- Weight writes:
  - Take effect at the clock edge when wr_en=1 and state==IDLE.
  - wr_en in any other state, or with wr_sel==3, drops the write and pulses wr_err the next cycle.
  - Out-of-range row/col also drops the write and pulses wr_err.
- FSM states: IDLE, CALC, WRITE, OUT. Counters: h (output index), e (input index).
  - IDLE: in_ready=1. On in_valid: latch in_vec_flat into an internal token register, h=0, e=0, clear accumulators, go to CALC. The weight write and token accept may occur on the same edge; the new weight is used for that token.
  - CALC: acc += x[e]*W[h][e] for Q/K/V. e increments; after e==EMBED_DIM-1 go to WRITE.
  - WRITE: round/saturate accumulators into element h of the Q/K/V output registers. If h==HEAD_DIM-1 go to OUT; else h++, e=0, clear accumulators, go to CALC.
  - OUT: out_valid=1, in_ready=0. Outputs are stable while waiting. On out_ready go to IDLE, out_valid drops the next cycle.
- Latency: out_valid rises HEAD_DIM*(EMBED_DIM+1) cycles after the accepting edge (72 at defaults).
- Throughput: one token per HEAD_DIM*(EMBED_DIM+1)+2 cycles minimum.
- Output registers hold their last result after the handshake, until overwritten element-by-element by the next token's WRITE cycles.
- in_vec_flat changes after the accepting edge have no effect.
- Reset, asynchronous and allowed mid-operation:
  - state=IDLE, counters=0, accumulators=0.
  - Q/K/V=0, out_valid=0, wr_err=0, sat_flag=0.
  - Weights return to identity; in_ready=1 after reset release.

Test Plan:
1. Reset weights, x=[16384,-8192,1,0,0,0,0,32767] -> Q=K=V=x; out_valid exactly 72 cycles after accept; sat_flag=0.
2. Set W_q[0][0]=32767 and x[0]=32767 -> Q[0]=32767, sat_flag=1. Then x[0]=-32768 -> Q[0]=-32768.
3. Set W_v[0][0]=8192 (0.5):
   - x[0]=3 -> V[0]=2.
   - x[0]=-3 -> V[0]=-1 (half rounds up).
   - x[0]=1 -> V[0]=1.
4. out_ready low 10 cycles in OUT -> out_valid, Q/K/V stable and in_ready=0 throughout. Raise out_ready with a second token pending -> accepted 2 cycles later; second result correct.
5. wr_en during CALC (W_k[1][1]=0) -> wr_err pulses once, K unaffected. Write with wr_sel=3 -> wr_err, no matrix changed.
6. Assert rst mid-CALC -> out_valid=0, Q/K/V=0, weights back to identity; next token matches scenario 1.
